// File: rtl/inst_seq_mem.sv
// inst_seq_mem
//   Instruction store with load/replay sequencing for one PE. A valid burst
//   is written to consecutive entries from address 0. When the burst ends,
//   the stored program is replayed from address 0. Replay is paced by
//   i_stall and can be repeated several times.
//
// Build option:
//   INST_MEM_LOOP_EN  defined   : i_loop_cnt sets the number of replay passes
//                                 (0 is treated as 1).
//                     undefined : i_loop_cnt is ignored and there is a single
//                                 replay pass.
//
// Parameters:
//   INST_WIDTH  instruction width
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH entries
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_valid           instruction load strobe (ignored during replay)
//   i_inst_in         instruction to load
//   i_stall           1 = do not issue a replay read this cycle
//   i_loop_cnt        replay pass count, sampled at the end of the load
//   o_inst_out        replayed instruction (registered; held while stalled)
//   o_inst_out_valid  o_inst_out carries a new instruction this cycle
//   o_prog_len        length of the last loaded program
//   o_busy            loading or replaying
//   o_done            pulse that coincides with the final replayed instruction
//   o_overflow        sticky; more than DEPTH instructions were offered in a burst
module inst_seq_mem #(
    parameter int unsigned INST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [INST_WIDTH-1:0] i_inst_in,
    input  logic                  i_stall,
    input  logic [7:0]            i_loop_cnt,
    output logic [INST_WIDTH-1:0] o_inst_out,
    output logic                  o_inst_out_valid,
    output logic [ADDR_WIDTH:0]   o_prog_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [ADDR_WIDTH:0]   r_wr_ptr,   w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   r_prog_len, w_prog_len_nxt;
    logic [ADDR_WIDTH-1:0] r_pc,       w_pc_nxt;
    logic [7:0]            r_pass,     w_pass_nxt;
    logic                  r_overflow, w_overflow_nxt;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic                  w_re;
    logic                  w_last_addr;
    logic                  w_last_pass;
    logic [7:0]            w_pass_init;

    logic [INST_WIDTH-1:0] r_mem [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_out;
    logic                  r_inst_out_valid;
    logic                  r_done;

`ifdef INST_MEM_LOOP_EN
    assign w_pass_init = (i_loop_cnt == 8'd0) ? 8'd1 : i_loop_cnt;
`else
    logic w_loop_cnt_unused;
    assign w_loop_cnt_unused = ^i_loop_cnt;
    assign w_pass_init       = 8'd1;
`endif

    // o_prog_len is at least 1 in RUN, so the subtraction cannot wrap there.
    assign w_last_addr = ({1'b0, r_pc} == (r_prog_len - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    assign w_last_pass = (r_pass == 8'd1);

    // Next-state and datapath control
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_prog_len_nxt = r_prog_len;
        w_pc_nxt       = r_pc;
        w_pass_nxt     = r_pass;
        w_overflow_nxt = r_overflow;
        w_we           = 1'b0;
        w_waddr        = r_wr_ptr[ADDR_WIDTH-1:0];
        w_re           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_we           = 1'b1;
                    w_waddr        = '0;
                    w_wr_ptr_nxt   = {{ADDR_WIDTH{1'b0}}, 1'b1};
                    w_overflow_nxt = 1'b0;
                    w_state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_valid) begin
                    // The MSB of the write pointer is set only once DEPTH entries are stored.
                    if (!r_wr_ptr[ADDR_WIDTH]) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end else begin
                    w_prog_len_nxt = r_wr_ptr;
                    w_pass_nxt     = w_pass_init;
                    w_pc_nxt       = '0;
                    w_state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_stall) begin
                    w_re = 1'b1;
                    if (w_last_addr) begin
                        w_pc_nxt   = '0;
                        w_pass_nxt = r_pass - 8'd1;
                        if (w_last_pass) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_wr_ptr         <= '0;
            r_prog_len       <= '0;
            r_pc             <= '0;
            r_pass           <= '0;
            r_overflow       <= 1'b0;
            r_inst_out       <= '0;
            r_inst_out_valid <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_wr_ptr         <= w_wr_ptr_nxt;
            r_prog_len       <= w_prog_len_nxt;
            r_pc             <= w_pc_nxt;
            r_pass           <= w_pass_nxt;
            r_overflow       <= w_overflow_nxt;
            r_inst_out_valid <= w_re;
            r_done           <= w_re && w_last_addr && w_last_pass;
            if (w_re) begin
                r_inst_out <= r_mem[r_pc];
            end
        end
    end

    // Storage is never cleared. The write is gated by reset so that a valid
    // that is high while reset is held cannot write an entry.
    always_ff @(posedge i_clk) begin
        if (w_we && !i_rst) begin
            r_mem[w_waddr] <= i_inst_in;
        end
    end

    assign o_inst_out       = r_inst_out;
    assign o_inst_out_valid = r_inst_out_valid;
    assign o_prog_len       = r_prog_len;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = r_done;
    assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_inst_seq_mem.sv
// tb_inst_seq_mem
//   Directed testbench for inst_seq_mem (INST_WIDTH=64, ADDR_WIDTH=4).
//   The expected pass count follows INST_MEM_LOOP_EN.
module tb_inst_seq_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [63:0] inst_in;
    logic        stall;
    logic [7:0]  loop_cnt;
    logic [63:0] inst_out;
    logic        inst_out_valid;
    logic [4:0]  prog_len;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] cap[$];
    int          done_pos;
    int          first_lat;
    int          gap;
    bit          held_ok;
    logic        done_busy;

    always #5 clk = ~clk;

    inst_seq_mem #(
        .INST_WIDTH(64),
        .ADDR_WIDTH(4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (valid),
        .i_inst_in        (inst_in),
        .i_stall          (stall),
        .i_loop_cnt       (loop_cnt),
        .o_inst_out       (inst_out),
        .o_inst_out_valid (inst_out_valid),
        .o_prog_len       (prog_len),
        .o_busy           (busy),
        .o_done           (done),
        .o_overflow       (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            valid   = 1'b1;
            inst_in = base + 64'(i);
            tick();
        end
    endtask

    // Drops valid and collects replayed instructions until done or the budget runs out.
    task automatic replay(input int stall_after, input int stall_len, input int pulse_at, input int budget);
        int  cyc        = 0;
        int  stall_left = 0;
        bit  stalled    = 1'b0;
        cap.delete();
        done_pos  = -1;
        first_lat = -1;
        gap       = 0;
        held_ok   = 1'b1;
        done_busy = 1'bx;
        valid     = 1'b0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (inst_out_valid) begin
                if (first_lat < 0) first_lat = cyc;
                cap.push_back(inst_out);
            end else if (first_lat >= 0) begin
                gap++;
                if (inst_out !== cap[$]) held_ok = 1'b0;
            end
            if (done) begin
                done_pos  = cap.size();
                done_busy = busy;
                break;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end
            if (!stalled && stall_len > 0 && cap.size() == stall_after) begin
                stall      = 1'b1;
                stall_left = stall_len;
                stalled    = 1'b1;
            end
            valid   = (cyc == pulse_at);
            inst_in = 64'hEE;
        end
        valid = 1'b0;
        stall = 1'b0;
        if (done_pos < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int exp_n;
        rst      = 1'b1;
        valid    = 1'b0;
        inst_in  = '0;
        stall    = 1'b0;
        loop_cnt = 8'd1;
        tick();
        tick();
        chk("rst_inst_out", inst_out, 64'd0);
        chk("rst_out_valid", 64'(inst_out_valid), 64'd0);
        chk("rst_prog_len", 64'(prog_len), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Basic load of 5 and single replay
        loop_cnt = 8'd1;
        load(64'h11, 5);
        chk("t1_busy_load", 64'(busy), 64'd1);
        replay(0, 0, -1, 40);
        chk("t1_prog_len", 64'(prog_len), 64'd5);
        chk("t1_count", 64'(cap.size()), 64'd5);
        for (int i = 0; i < cap.size() && i < 5; i++) chk($sformatf("t1_data%0d", i), cap[i], 64'h11 + 64'(i));
        chk("t1_first_lat", 64'(first_lat), 64'd2);
        chk("t1_done_pos", 64'(done_pos), 64'd5);
        chk("t1_done_busy", 64'(done_busy), 64'd0);
        chk("t1_gap", 64'(gap), 64'd0);
        chk("t1_overflow", 64'(overflow), 64'd0);
        tick();
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Multi-pass replay
        loop_cnt = 8'd3;
`ifdef INST_MEM_LOOP_EN
        exp_n = 15;
`else
        exp_n = 5;
`endif
        load(64'h11, 5);
        replay(0, 0, -1, 80);
        chk("t2_count", 64'(cap.size()), 64'(exp_n));
        chk("t2_done_pos", 64'(done_pos), 64'(exp_n));
        for (int i = 0; i < cap.size() && i < exp_n; i++) chk($sformatf("t2_data%0d", i), cap[i], 64'h11 + 64'(i % 5));
        loop_cnt = 8'd1;
        tick();

        // Overflow: 20 offered, 16 kept
        load(64'h100, 20);
        replay(0, 0, -1, 60);
        chk("t3_prog_len", 64'(prog_len), 64'd16);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_count", 64'(cap.size()), 64'd16);
        for (int i = 0; i < cap.size() && i < 16; i++) chk($sformatf("t3_data%0d", i), cap[i], 64'h100 + 64'(i));
        tick();

        // Stall for 3 cycles after the 2nd output
        load(64'h41, 4);
        chk("t4_overflow_clr", 64'(overflow), 64'd0);
        replay(2, 3, -1, 40);
        chk("t4_count", 64'(cap.size()), 64'd4);
        chk("t4_gap", 64'(gap), 64'd3);
        chk("t4_held", 64'(held_ok), 64'd1);
        for (int i = 0; i < cap.size() && i < 4; i++) chk($sformatf("t4_data%0d", i), cap[i], 64'h41 + 64'(i));
        chk("t4_done_pos", 64'(done_pos), 64'd4);
        tick();

        // valid pulsed during RUN is ignored
        load(64'h51, 3);
        replay(0, 0, 2, 40);
        chk("t5_count", 64'(cap.size()), 64'd3);
        for (int i = 0; i < cap.size() && i < 3; i++) chk($sformatf("t5_data%0d", i), cap[i], 64'h51 + 64'(i));
        chk("t5_prog_len", 64'(prog_len), 64'd3);
        tick();
        chk("t5_idle_busy", 64'(busy), 64'd0);
        load(64'hA0, 2);
        replay(0, 0, -1, 40);
        chk("t5b_count", 64'(cap.size()), 64'd2);
        for (int i = 0; i < cap.size() && i < 2; i++) chk($sformatf("t5b_data%0d", i), cap[i], 64'hA0 + 64'(i));
        chk("t5b_prog_len", 64'(prog_len), 64'd2);
        tick();

        // Reset mid-RUN
        load(64'h61, 4);
        valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_running", 64'(inst_out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_inst_out", inst_out, 64'd0);
        chk("t6_rst_valid", 64'(inst_out_valid), 64'd0);
        chk("t6_rst_prog_len", 64'(prog_len), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_after_valid", 64'(inst_out_valid), 64'd0);
        chk("t6_after_busy", 64'(busy), 64'd0);
        load(64'h7F, 1);
        replay(0, 0, -1, 20);
        chk("t6_count", 64'(cap.size()), 64'd1);
        if (cap.size() > 0) chk("t6_data", cap[0], 64'h7F);
        chk("t6_done_pos", 64'(done_pos), 64'd1);
        chk("t6_prog_len", 64'(prog_len), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
